request_tagger: RTL

Front-end stage directly upstream of the returner. It accepts host read/write requests through a valid/ready handshake and stamps each one with an in-order sequence index: a separate counter for reads and one for writes. It forwards the tagged request to the scheduler/back end through a 2-entry buffer that preserves order. It also tracks outstanding reads and writes, and retires them on the returner's done pulses, so no index is reused while the returner still holds it.

---
 rtl/request_tagger.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/request_tagger.sv
// request_tagger: tags host read/write requests with in-order per-type
// sequence indices, forwards them through a 2-entry order-preserving
// buffer (output register + skid register) and tracks outstanding
// reads/writes so an index is never reissued while still held downstream.
module request_tagger #(
    parameter int data_width        = 16,
    parameter int addr_width        = 16,
    parameter int read_entries_log  = 6,
    parameter int write_entries_log = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_type,
    input  logic [addr_width-1:0]        in_addr,
    input  logic [data_width-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_type,
    output logic [addr_width-1:0]        out_addr,
    output logic [data_width-1:0]        out_data,
    output logic [read_entries_log-1:0]  out_index,
    input  logic                         read_done,
    input  logic                         write_done,
    output logic [read_entries_log:0]    read_outstanding,
    output logic [write_entries_log:0]   write_outstanding,
    output logic                         underflow_err
);

    localparam int RL = read_entries_log;
    localparam int WL = write_entries_log;

    // Tag counters and outstanding counters
    logic [RL-1:0] rd_tag_q, rd_tag_d;
    logic [WL-1:0] wr_tag_q, wr_tag_d;
    logic [RL:0]   rd_cnt_q, rd_cnt_d;
    logic [WL:0]   wr_cnt_q, wr_cnt_d;
    logic          underflow_q, underflow_d;

    // Output register
    logic                  out_valid_q, out_valid_d;
    logic                  out_type_q, out_type_d;
    logic [addr_width-1:0] out_addr_q, out_addr_d;
    logic [data_width-1:0] out_data_q, out_data_d;
    logic [RL-1:0]         out_index_q, out_index_d;

    // Skid register
    logic                  skid_valid_q, skid_valid_d;
    logic                  skid_type_q, skid_type_d;
    logic [addr_width-1:0] skid_addr_q, skid_addr_d;
    logic [data_width-1:0] skid_data_q, skid_data_d;
    logic [RL-1:0]         skid_index_q, skid_index_d;

    logic          credit_ok;
    logic          accept;
    logic          out_free;
    logic          rd_acc;
    logic          wr_acc;
    logic [RL-1:0] new_index;

    // A count at exactly 2^log has its top bit set, so the top bit alone
    // tells us the type has run out of indices.
    assign credit_ok = in_type ? !wr_cnt_q[WL] : !rd_cnt_q[RL];
    assign in_ready  = !rst && !skid_valid_q && credit_ok;
    assign accept    = in_valid && in_ready;
    assign rd_acc    = accept && !in_type;
    assign wr_acc    = accept && in_type;
    // Output register can take new content when empty or being drained now
    assign out_free  = !out_valid_q || out_ready;

    // Index stamped on the incoming request; write tags are zero-extended
    always_comb begin
        new_index = '0;
        if (in_type) begin
            new_index[WL-1:0] = wr_tag_q;
        end else begin
            new_index = rd_tag_q;
        end
    end

    // Next-state: buffer movement, tag increments, outstanding accounting
    always_comb begin
        out_valid_d  = out_valid_q;
        out_type_d   = out_type_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        out_index_d  = out_index_q;
        skid_valid_d = skid_valid_q;
        skid_type_d  = skid_type_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        skid_index_d = skid_index_q;
        rd_tag_d     = rd_tag_q;
        wr_tag_d     = wr_tag_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        underflow_d  = underflow_q;

        if (out_free) begin
            // Skid content is older than anything arriving now; while the
            // skid is full no new request can be accepted anyway.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_type_d   = skid_type_q;
                out_addr_d   = skid_addr_q;
                out_data_d   = skid_data_q;
                out_index_d  = skid_index_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d  = 1'b1;
                out_type_d   = in_type;
                out_addr_d   = in_addr;
                out_data_d   = in_data;
                out_index_d  = new_index;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_type_d  = in_type;
            skid_addr_d  = in_addr;
            skid_data_d  = in_data;
            skid_index_d = new_index;
        end

        if (rd_acc) begin
            rd_tag_d = rd_tag_q + RL'(1);
        end
        if (wr_acc) begin
            wr_tag_d = wr_tag_q + WL'(1);
        end

        if (read_done && rd_cnt_q == '0) begin
            underflow_d = 1'b1;
        end
        if (write_done && wr_cnt_q == '0) begin
            underflow_d = 1'b1;
        end

        if (rd_acc && !read_done) begin
            rd_cnt_d = rd_cnt_q + (RL+1)'(1);
        end else if (!rd_acc && read_done && rd_cnt_q != '0) begin
            rd_cnt_d = rd_cnt_q - (RL+1)'(1);
        end

        if (wr_acc && !write_done) begin
            wr_cnt_d = wr_cnt_q + (WL+1)'(1);
        end else if (!wr_acc && write_done && wr_cnt_q != '0) begin
            wr_cnt_d = wr_cnt_q - (WL+1)'(1);
        end
    end

    // State registers; reset drops buffered requests and zeroes all counters
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_type_q   <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            out_index_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_type_q  <= 1'b0;
            skid_addr_q  <= '0;
            skid_data_q  <= '0;
            skid_index_q <= '0;
            rd_tag_q     <= '0;
            wr_tag_q     <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            underflow_q  <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_type_q   <= out_type_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            out_index_q  <= out_index_d;
            skid_valid_q <= skid_valid_d;
            skid_type_q  <= skid_type_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            skid_index_q <= skid_index_d;
            rd_tag_q     <= rd_tag_d;
            wr_tag_q     <= wr_tag_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            underflow_q  <= underflow_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_type          = out_type_q;
    assign out_addr          = out_addr_q;
    assign out_data          = out_data_q;
    assign out_index         = out_index_q;
    assign read_outstanding  = rd_cnt_q;
    assign write_outstanding = wr_cnt_q;
    assign underflow_err     = underflow_q;

endmodule
